// File: rtl/ysyx_22041071_axi_rd_arb_if.sv
// rtl/ysyx_22041071_axi_rd_arb_if.sv - fetch/load-store request ports and shared AXI read channel
// slave: arbiter view; master: the environment driving requests and the AXI read slave.
interface ysyx_22041071_axi_rd_arb_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
);
  logic              if_req_valid;
  logic [ADDR_W-1:0] if_req_addr;
  logic [7:0]        if_req_len;
  logic [1:0]        if_req_size;
  logic              if_req_ready;
  logic              if_rsp_valid;
  logic [DATA_W-1:0] if_rsp_data;
  logic [1:0]        if_rsp_resp;
  logic              if_rsp_last;

  logic              ls_req_valid;
  logic [ADDR_W-1:0] ls_req_addr;
  logic [7:0]        ls_req_len;
  logic [1:0]        ls_req_size;
  logic              ls_req_ready;
  logic              ls_rsp_valid;
  logic [DATA_W-1:0] ls_rsp_data;
  logic [1:0]        ls_rsp_resp;
  logic              ls_rsp_last;

  logic              mst_ar_valid;
  logic              mst_ar_ready;
  logic [ID_W-1:0]   mst_id;
  logic [ADDR_W-1:0] mst_addr;
  logic [7:0]        mst_len;
  logic [1:0]        mst_size;
  logic              mst_r_valid;
  logic [DATA_W-1:0] mst_r_data;
  logic [1:0]        mst_r_resp;
  logic              mst_r_last;
  logic [ID_W-1:0]   mst_r_id;

  modport slave (
    input  if_req_valid, if_req_addr, if_req_len, if_req_size,
    output if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_resp, if_rsp_last,
    input  ls_req_valid, ls_req_addr, ls_req_len, ls_req_size,
    output ls_req_ready, ls_rsp_valid, ls_rsp_data, ls_rsp_resp, ls_rsp_last,
    output mst_ar_valid, mst_id, mst_addr, mst_len, mst_size,
    input  mst_ar_ready,
    input  mst_r_valid, mst_r_data, mst_r_resp, mst_r_last, mst_r_id
  );

  modport master (
    output if_req_valid, if_req_addr, if_req_len, if_req_size,
    input  if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_resp, if_rsp_last,
    output ls_req_valid, ls_req_addr, ls_req_len, ls_req_size,
    input  ls_req_ready, ls_rsp_valid, ls_rsp_data, ls_rsp_resp, ls_rsp_last,
    input  mst_ar_valid, mst_id, mst_addr, mst_len, mst_size,
    output mst_ar_ready,
    output mst_r_valid, mst_r_data, mst_r_resp, mst_r_last, mst_r_id
  );
endinterface

// File: rtl/ysyx_22041071_axi_rd_arb.sv
// rtl/ysyx_22041071_axi_rd_arb.sv - two-requester AXI read arbiter, one burst outstanding
// Ties go to load-store unless YSYX_22041071_ARB_RR_EN is defined, which enables round-robin.
module ysyx_22041071_axi_rd_arb #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  ysyx_22041071_axi_rd_arb_if.slave   bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  logic [1:0]        state;
  logic              owner;
  logic [ID_W-1:0]   id_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        len_q;
  logic [1:0]        size_q;
  logic [8:0]        beat_cnt;

  logic              if_rsp_valid_q;
  logic [DATA_W-1:0] if_rsp_data_q;
  logic [1:0]        if_rsp_resp_q;
  logic              if_rsp_last_q;
  logic              ls_rsp_valid_q;
  logic [DATA_W-1:0] ls_rsp_data_q;
  logic [1:0]        ls_rsp_resp_q;
  logic              ls_rsp_last_q;

  logic grant_any;
  logic grant_ls;

`ifdef YSYX_22041071_ARB_RR_EN
  // Pointer holds 1 when load-store was granted last; reset says fetch was.
  logic rr_last_ls;

  assign grant_ls = bus.ls_req_valid & (~bus.if_req_valid | ~rr_last_ls);

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_last_ls <= 1'b0;
    end else if (grant_any) begin
      rr_last_ls <= grant_ls;
    end
  end
`else
  assign grant_ls = bus.ls_req_valid;
`endif

  assign grant_any = ~reset & (state == S_IDLE) & (bus.if_req_valid | bus.ls_req_valid);

  assign bus.if_req_ready = grant_any & ~grant_ls;
  assign bus.ls_req_ready = grant_any & grant_ls;

  assign bus.mst_ar_valid = (state == S_ADDR);
  assign bus.mst_id       = id_q;
  assign bus.mst_addr     = addr_q;
  assign bus.mst_len      = len_q;
  assign bus.mst_size     = size_q;

  assign bus.if_rsp_valid = if_rsp_valid_q;
  assign bus.if_rsp_data  = if_rsp_data_q;
  assign bus.if_rsp_resp  = if_rsp_resp_q;
  assign bus.if_rsp_last  = if_rsp_last_q;
  assign bus.ls_rsp_valid = ls_rsp_valid_q;
  assign bus.ls_rsp_data  = ls_rsp_data_q;
  assign bus.ls_rsp_resp  = ls_rsp_resp_q;
  assign bus.ls_rsp_last  = ls_rsp_last_q;

  logic       beat_in;
  logic [8:0] beat_num;
  logic [8:0] beat_total;
  logic       id_bad;
  logic       len_bad;
  logic [1:0] beat_resp;

  assign beat_in    = (state == S_DATA) & bus.mst_r_valid;
  assign beat_num   = beat_cnt + 9'd1;
  assign beat_total = {1'b0, len_q} + 9'd1;
  assign id_bad     = (bus.mst_r_id != id_q);
  // A last flag must land exactly on beat len+1; any non-last beat from len+1 onward is overrun.
  assign len_bad    = bus.mst_r_last ? (beat_num != beat_total) : (beat_num >= beat_total);
  assign beat_resp  = (id_bad | len_bad) ? 2'b10 : bus.mst_r_resp;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      owner          <= 1'b0;
      id_q           <= '0;
      addr_q         <= '0;
      len_q          <= '0;
      size_q         <= '0;
      beat_cnt       <= '0;
      if_rsp_valid_q <= 1'b0;
      if_rsp_data_q  <= '0;
      if_rsp_resp_q  <= '0;
      if_rsp_last_q  <= 1'b0;
      ls_rsp_valid_q <= 1'b0;
      ls_rsp_data_q  <= '0;
      ls_rsp_resp_q  <= '0;
      ls_rsp_last_q  <= 1'b0;
    end else begin
      if_rsp_valid_q <= 1'b0;
      if_rsp_last_q  <= 1'b0;
      ls_rsp_valid_q <= 1'b0;
      ls_rsp_last_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_any) begin
            owner  <= grant_ls;
            id_q   <= ID_W'(grant_ls);
            addr_q <= grant_ls ? bus.ls_req_addr : bus.if_req_addr;
            len_q  <= grant_ls ? bus.ls_req_len  : bus.if_req_len;
            size_q <= grant_ls ? bus.ls_req_size : bus.if_req_size;
            state  <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (bus.mst_ar_ready) begin
            beat_cnt <= '0;
            state    <= S_DATA;
          end
        end
        S_DATA: begin
          if (beat_in) begin
            if (beat_cnt != 9'h1ff) begin
              beat_cnt <= beat_num;
            end
            if (owner) begin
              ls_rsp_valid_q <= 1'b1;
              ls_rsp_data_q  <= bus.mst_r_data;
              ls_rsp_resp_q  <= beat_resp;
              ls_rsp_last_q  <= bus.mst_r_last;
            end else begin
              if_rsp_valid_q <= 1'b1;
              if_rsp_data_q  <= bus.mst_r_data;
              if_rsp_resp_q  <= beat_resp;
              if_rsp_last_q  <= bus.mst_r_last;
            end
            if (bus.mst_r_last) begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_22041071_axi_rd_arb.sv
// tb/tb_ysyx_22041071_axi_rd_arb.sv - directed self-checking bench for the AXI read arbiter
module tb_ysyx_22041071_axi_rd_arb;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  ysyx_22041071_axi_rd_arb_if #(.ADDR_W(64), .DATA_W(64), .ID_W(4)) bus ();

  ysyx_22041071_axi_rd_arb #(.ADDR_W(64), .DATA_W(64), .ID_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    bus.if_req_valid = 1'b0; bus.if_req_addr = '0; bus.if_req_len = '0; bus.if_req_size = '0;
    bus.ls_req_valid = 1'b0; bus.ls_req_addr = '0; bus.ls_req_len = '0; bus.ls_req_size = '0;
    bus.mst_ar_ready = 1'b0; bus.mst_r_valid = 1'b0; bus.mst_r_data = '0;
    bus.mst_r_resp = '0; bus.mst_r_last = 1'b0; bus.mst_r_id = '0;
  endtask

  task automatic start_req(input logic fv, input logic lv,
                           input logic [63:0] fa, input logic [63:0] la,
                           input logic [7:0] fl, input logic [7:0] ll,
                           input logic [1:0] fs, input logic [1:0] lsz);
    @(posedge clk); #1;
    bus.if_req_valid = fv; bus.if_req_addr = fa; bus.if_req_len = fl; bus.if_req_size = fs;
    bus.ls_req_valid = lv; bus.ls_req_addr = la; bus.ls_req_len = ll; bus.ls_req_size = lsz;
    @(negedge clk);
  endtask

  task automatic end_req();
    @(posedge clk); #1;
    bus.if_req_valid = 1'b0;
    bus.ls_req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic ar_accept();
    @(posedge clk); #1;
    bus.mst_ar_ready = 1'b1;
    @(posedge clk); #1;
    bus.mst_ar_ready = 1'b0;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic l, input logic [3:0] id);
    @(posedge clk); #1;
    bus.mst_r_valid = 1'b1; bus.mst_r_data = d; bus.mst_r_last = l;
    bus.mst_r_id = id; bus.mst_r_resp = 2'b00;
    @(posedge clk); #1;
    bus.mst_r_valid = 1'b0; bus.mst_r_last = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.if_req_ready, bus.ls_req_ready, bus.mst_ar_valid, bus.if_rsp_valid,
         bus.ls_rsp_valid, bus.if_rsp_last, bus.ls_rsp_last} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b want 0000000", {bus.if_req_ready, bus.ls_req_ready,
               bus.mst_ar_valid, bus.if_rsp_valid, bus.ls_rsp_valid, bus.if_rsp_last, bus.ls_rsp_last});
    end
    checks++;
    if ({bus.mst_id, bus.mst_addr, bus.mst_len, bus.mst_size} !== 78'b0) begin
      failures++;
      $display("FAIL reset_fields: id=%h addr=%h len=%h size=%h want 0", bus.mst_id, bus.mst_addr,
               bus.mst_len, bus.mst_size);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_lone_fetch();
    start_req(1'b1, 1'b0, 64'h8000_0000, 64'h0, 8'd0, 8'd0, 2'b11, 2'b00);
    checks++;
    if ({bus.if_req_ready, bus.ls_req_ready} !== 2'b10) begin
      failures++;
      $display("FAIL fetch_ready: got %b want 10", {bus.if_req_ready, bus.ls_req_ready});
    end
    @(posedge clk); #1;
    bus.if_req_valid = 1'b0;
    bus.mst_r_valid = 1'b1; bus.mst_r_last = 1'b1; bus.mst_r_data = 64'hdead;
    for (int w = 0; w < 3; w++) begin
      @(negedge clk);
      checks++;
      if ({bus.mst_ar_valid, bus.mst_id, bus.mst_addr, bus.mst_len, bus.mst_size, bus.if_req_ready,
           bus.if_rsp_valid} !== {1'b1, 4'd0, 64'h8000_0000, 8'd0, 2'b11, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL fetch_ar_wait%0d: arv=%b id=%h addr=%h len=%h size=%b rdy=%b rspv=%b", w,
                 bus.mst_ar_valid, bus.mst_id, bus.mst_addr, bus.mst_len, bus.mst_size,
                 bus.if_req_ready, bus.if_rsp_valid);
      end
      @(posedge clk); #1;
    end
    bus.mst_r_valid = 1'b0; bus.mst_r_last = 1'b0;
    bus.mst_ar_ready = 1'b1;
    @(posedge clk); #1;
    bus.mst_ar_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.mst_ar_valid !== 1'b0 || bus.if_rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL fetch_ar_drop: arv=%b rspv=%b want 0 0", bus.mst_ar_valid, bus.if_rsp_valid);
    end
    send_beat(64'h1122_3344_5566_7788, 1'b1, 4'd0);
    checks++;
    if ({bus.if_rsp_valid, bus.if_rsp_last, bus.if_rsp_resp, bus.if_rsp_data, bus.ls_rsp_valid}
        !== {1'b1, 1'b1, 2'b00, 64'h1122_3344_5566_7788, 1'b0}) begin
      failures++;
      $display("FAIL fetch_beat: v=%b last=%b resp=%b data=%h lsv=%b want 1 1 00 1122334455667788 0",
               bus.if_rsp_valid, bus.if_rsp_last, bus.if_rsp_resp, bus.if_rsp_data, bus.ls_rsp_valid);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (bus.if_rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL fetch_single_pulse: got %b want 0", bus.if_rsp_valid);
    end
  endtask

  task automatic test_tie();
    logic exp_ls;
    for (int r = 0; r < 3; r++) begin
`ifdef YSYX_22041071_ARB_RR_EN
      exp_ls = (r != 1);
`else
      exp_ls = 1'b1;
`endif
      start_req(1'b1, 1'b1, 64'h100 + 64'(r), 64'h200 + 64'(r), 8'd0, 8'd0, 2'b10, 2'b01);
      checks++;
      if ({bus.if_req_ready, bus.ls_req_ready} !== {~exp_ls, exp_ls}) begin
        failures++;
        $display("FAIL tie%0d_grant: got %b want %b", r, {bus.if_req_ready, bus.ls_req_ready},
                 {~exp_ls, exp_ls});
      end
      end_req();
      checks++;
      if ({bus.mst_id, bus.mst_addr, bus.mst_size} !==
          {{3'b0, exp_ls}, exp_ls ? 64'h200 + 64'(r) : 64'h100 + 64'(r), exp_ls ? 2'b01 : 2'b10}) begin
        failures++;
        $display("FAIL tie%0d_fields: id=%h addr=%h size=%b want ls=%b", r, bus.mst_id, bus.mst_addr,
                 bus.mst_size, exp_ls);
      end
      ar_accept();
      send_beat(64'hab00 + 64'(r), 1'b1, {3'b0, exp_ls});
      checks++;
      if ({bus.if_rsp_valid, bus.ls_rsp_valid} !== {~exp_ls, exp_ls}) begin
        failures++;
        $display("FAIL tie%0d_route: got %b want %b", r, {bus.if_rsp_valid, bus.ls_rsp_valid},
                 {~exp_ls, exp_ls});
      end
    end
  endtask

  task automatic test_ls_burst();
    start_req(1'b0, 1'b1, 64'h0, 64'h1000, 8'd0, 8'd3, 2'b00, 2'b11);
    checks++;
    if (bus.ls_req_ready !== 1'b1) begin
      failures++;
      $display("FAIL ls_ready: got %b want 1", bus.ls_req_ready);
    end
    end_req();
    ar_accept();
    for (int i = 0; i < 4; i++) begin
      send_beat(64'ha0 + 64'(i), i == 3, 4'd1);
      checks++;
      if ({bus.ls_rsp_valid, bus.ls_rsp_last, bus.ls_rsp_resp, bus.ls_rsp_data, bus.if_rsp_valid, dut.state}
          !== {1'b1, i == 3, 2'b00, 64'ha0 + 64'(i), 1'b0, (i == 3) ? 2'd0 : 2'd2}) begin
        failures++;
        $display("FAIL ls_beat%0d: v=%b last=%b resp=%b data=%h ifv=%b state=%0d", i, bus.ls_rsp_valid,
                 bus.ls_rsp_last, bus.ls_rsp_resp, bus.ls_rsp_data, bus.if_rsp_valid, dut.state);
      end
    end
  endtask

  task automatic test_early_last();
    start_req(1'b1, 1'b0, 64'h3000, 64'h0, 8'd3, 8'd0, 2'b11, 2'b00);
    end_req();
    ar_accept();
    send_beat(64'h51, 1'b0, 4'd0);
    checks++;
    if ({bus.if_rsp_valid, bus.if_rsp_last, bus.if_rsp_resp, dut.state} !== {1'b1, 1'b0, 2'b00, 2'd2}) begin
      failures++;
      $display("FAIL early_beat1: v=%b last=%b resp=%b state=%0d want 1 0 00 2", bus.if_rsp_valid,
               bus.if_rsp_last, bus.if_rsp_resp, dut.state);
    end
    send_beat(64'h52, 1'b1, 4'd0);
    checks++;
    if ({bus.if_rsp_valid, bus.if_rsp_last, bus.if_rsp_resp, dut.state} !== {1'b1, 1'b1, 2'b10, 2'd0}) begin
      failures++;
      $display("FAIL early_beat2: v=%b last=%b resp=%b state=%0d want 1 1 10 0", bus.if_rsp_valid,
               bus.if_rsp_last, bus.if_rsp_resp, dut.state);
    end
  endtask

  task automatic test_errors();
    start_req(1'b0, 1'b1, 64'h0, 64'h4000, 8'd0, 8'd0, 2'b00, 2'b10);
    end_req();
    ar_accept();
    send_beat(64'h61, 1'b0, 4'd0);
    checks++;
    if ({bus.ls_rsp_valid, bus.ls_rsp_last, bus.ls_rsp_resp, dut.state} !== {1'b1, 1'b0, 2'b10, 2'd2}) begin
      failures++;
      $display("FAIL missing_last: v=%b last=%b resp=%b state=%0d want 1 0 10 2", bus.ls_rsp_valid,
               bus.ls_rsp_last, bus.ls_rsp_resp, dut.state);
    end
    send_beat(64'h62, 1'b1, 4'd1);
    checks++;
    if ({bus.ls_rsp_valid, bus.ls_rsp_last, bus.ls_rsp_resp, dut.state} !== {1'b1, 1'b1, 2'b10, 2'd0}) begin
      failures++;
      $display("FAIL overrun_last: v=%b last=%b resp=%b state=%0d want 1 1 10 0", bus.ls_rsp_valid,
               bus.ls_rsp_last, bus.ls_rsp_resp, dut.state);
    end
    start_req(1'b1, 1'b0, 64'h5000, 64'h0, 8'd0, 8'd0, 2'b11, 2'b00);
    end_req();
    ar_accept();
    send_beat(64'h63, 1'b1, 4'd1);
    checks++;
    if ({bus.if_rsp_valid, bus.if_rsp_last, bus.if_rsp_resp, dut.state} !== {1'b1, 1'b1, 2'b10, 2'd0}) begin
      failures++;
      $display("FAIL id_mismatch: v=%b last=%b resp=%b state=%0d want 1 1 10 0", bus.if_rsp_valid,
               bus.if_rsp_last, bus.if_rsp_resp, dut.state);
    end
  endtask

  task automatic test_reset_mid_burst();
    start_req(1'b1, 1'b0, 64'h6000, 64'h0, 8'd7, 8'd0, 2'b11, 2'b00);
    end_req();
    ar_accept();
    send_beat(64'h71, 1'b0, 4'd0);
    send_beat(64'h72, 1'b0, 4'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    bus.mst_r_valid = 1'b1; bus.mst_r_data = 64'h73; bus.mst_r_id = 4'd0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.if_req_ready, bus.ls_req_ready, bus.mst_ar_valid, bus.if_rsp_valid, bus.ls_rsp_valid,
         bus.if_rsp_last, bus.if_rsp_resp, bus.if_rsp_data, bus.mst_addr, bus.mst_len, dut.state} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs: arv=%b ifv=%b data=%h addr=%h len=%h state=%0d want all 0",
               bus.mst_ar_valid, bus.if_rsp_valid, bus.if_rsp_data, bus.mst_addr, bus.mst_len, dut.state);
    end
    @(posedge clk); #1;
    bus.mst_r_last = 1'b1;
    @(posedge clk); #1;
    bus.mst_r_valid = 1'b0; bus.mst_r_last = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.if_rsp_valid, bus.ls_rsp_valid, dut.state} !== 4'b0) begin
      failures++;
      $display("FAIL midreset_ignore: ifv=%b lsv=%b state=%0d want 0 0 0", bus.if_rsp_valid,
               bus.ls_rsp_valid, dut.state);
    end
    start_req(1'b0, 1'b1, 64'h0, 64'h7000, 8'd0, 8'd0, 2'b00, 2'b11);
    checks++;
    if ({bus.if_req_ready, bus.ls_req_ready} !== 2'b01) begin
      failures++;
      $display("FAIL midreset_regrant: got %b want 01", {bus.if_req_ready, bus.ls_req_ready});
    end
    end_req();
    checks++;
    if ({bus.mst_ar_valid, bus.mst_id, bus.mst_addr} !== {1'b1, 4'd1, 64'h7000}) begin
      failures++;
      $display("FAIL midreset_ar: arv=%b id=%h addr=%h want 1 1 7000", bus.mst_ar_valid, bus.mst_id,
               bus.mst_addr);
    end
    ar_accept();
    send_beat(64'h81, 1'b1, 4'd1);
    checks++;
    if ({bus.ls_rsp_valid, bus.ls_rsp_last, bus.ls_rsp_resp, bus.ls_rsp_data} !== {1'b1, 1'b1, 2'b00, 64'h81}) begin
      failures++;
      $display("FAIL midreset_beat: v=%b last=%b resp=%b data=%h want 1 1 00 81", bus.ls_rsp_valid,
               bus.ls_rsp_last, bus.ls_rsp_resp, bus.ls_rsp_data);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    test_reset();
    test_lone_fetch();
    test_tie();
    test_ls_burst();
    test_early_last();
    test_errors();
    test_reset_mid_burst();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
